// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder: one full-adder bit per clock, LSB first.
// Computes {cout, sum} = a + b + cin over WIDTH RUN cycles.
//
// Handshake: start is a request that is accepted only in IDLE (busy=0,
// done=0); a, b and cin are captured on that same rising edge and are not
// looked at again. While RUN or DONE, start is ignored; nothing is queued.
// done is a one-cycle pulse marking sum/cout valid; they then hold until
// the next accepted start.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous active-high reset
//   start in   1      begin an addition (sampled only in IDLE)
//   a     in   WIDTH  augend, captured when start is accepted
//   b     in   WIDTH  addend, captured when start is accepted
//   cin   in   1      carry-in, captured when start is accepted
//   busy  out  1      high exactly while in RUN
//   done  out  1      one-cycle pulse, sum/cout valid
//   sum   out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout  out  1      carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    // Full-adder slice on the current LSBs of the operand shift registers.
    always_comb begin
        x        = op_a[0];
        y        = op_b[0];
        s_bit    = x ^ y ^ carry;
        c_next   = (x & y) | (carry & (x ^ y));
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath. sum fills from the MSB end so that after WIDTH shifts bit 0
    // of the result sits at sum[0]. cout is only written on the final bit so
    // it keeps the previous result's value while a new addition runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= c_next;
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    // Wraps to zero on the last bit when WIDTH is a power of
                    // two; harmless, the counter is reloaded on the next start.
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        cout <= c_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder. Two instances share clock and reset:
// dut8 (WIDTH=8) for directed, abort and randomized additions, and dut3
// (WIDTH=3) for the exhaustive back-to-back sweep. Expected results come from
// plain integer addition of the operands, held in scoreboard queues.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals ----------------
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       cin3;
    logic       busy3;
    logic       done3;
    logic [2:0] sum3;
    logic       cout3;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .start(start8),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .busy (busy8),
        .done (done8),
        .sum  (sum8),
        .cout (cout8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk  (clk),
        .rst  (rst),
        .start(start3),
        .a    (a3),
        .b    (b3),
        .cin  (cin3),
        .busy (busy3),
        .done (done3),
        .sum  (sum3),
        .cout (cout3)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [3:0] exp_q3[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; outputs are stable there
    // and inputs changed here are sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver (WIDTH=8) ----------------
    // One addition on dut8. Operand inputs are scrambled right after
    // acceptance; with inject set, a second start with other operands is
    // pulsed mid-RUN and must be ignored.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input bit inject);
        logic [8:0] exp;
        int         busy_n;
        bit         seen;
        int         extra;
        a8     = ta;
        b8     = tb_v;
        cin8   = tc;
        start8 = 1'b1;
        exp_q.push_back(9'(ta) + 9'(tb_v) + 9'(tc));
        tick();
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            check("busy_done_excl", {31'd0, busy8 & done8}, 32'd0);
            if (done8) begin
                seen = 1'b1;
            end else begin
                if (busy8) busy_n++;
                if (inject) begin
                    if (i == 2) begin
                        start8 = 1'b1;
                        a8     = 8'hAA;
                        b8     = 8'h55;
                    end else begin
                        start8 = 1'b0;
                    end
                end
                tick();
            end
        end
        start8 = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        check("busy_cycles", busy_n, 8);
        if (seen) begin
            exp = exp_q.pop_front();
            check("sum8", {24'd0, sum8}, {24'd0, exp[7:0]});
            check("cout8", {31'd0, cout8}, {31'd0, exp[8]});
            tick();
            check("done_single", {31'd0, done8}, 32'd0);
            check("sum8_hold", {24'd0, sum8}, {24'd0, exp[7:0]});
            check("cout8_hold", {31'd0, cout8}, {31'd0, exp[8]});
        end else begin
            exp_q.delete();
        end
        if (inject) begin
            extra = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (done8) extra++;
            end
            check("no_second_done", extra, 0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [2:0] ta3;
    logic [2:0] tb3;
    logic       tc3;
    logic [3:0] e3;
    int         prev_done;
    bit         seen3;
    int         done_cnt;

    initial begin
        rst    = 1'b1;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        cin8   = 1'b0;
        start3 = 1'b0;
        a3     = '0;
        b3     = '0;
        cin3   = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_sum8", {24'd0, sum8}, 32'd0);
        check("rst_cout8", {31'd0, cout8}, 32'd0);
        check("rst_busy3", {31'd0, busy3}, 32'd0);
        check("rst_sum3", {29'd0, sum3}, 32'd0);

        // Start held during a reset edge is ignored.
        start8 = 1'b1;
        a8     = 8'h12;
        b8     = 8'h34;
        tick();
        start8 = 1'b0;
        rst    = 1'b0;
        tick();
        check("start_in_rst_ignored", {31'd0, busy8}, 32'd0);

        // Directed cases
        run8(8'h5A, 8'h33, 1'b0, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1, 1'b0);
        run8(8'h00, 8'h00, 1'b1, 1'b0);
        run8(8'h10, 8'h20, 1'b0, 1'b1);

        // Reset 4 cycles into RUN aborts the operation.
        a8     = 8'h77;
        b8     = 8'h66;
        cin8   = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        check("pre_abort_busy", {31'd0, busy8}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_sum", {24'd0, sum8}, 32'd0);
        check("abort_cout", {31'd0, cout8}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done8) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        // Release between edges: the very next edge must accept a start.
        rst = 1'b0;
        run8(8'h01, 8'h01, 1'b0, 1'b0);

        // Randomized additions
        for (int i = 0; i < 20; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        // WIDTH=3 exhaustive sweep with start held high (back-to-back).
        prev_done = -1;
        for (int i = 0; i < 128; i++) begin
            tc3    = i[0];
            tb3    = i[3:1];
            ta3    = i[6:4];
            a3     = ta3;
            b3     = tb3;
            cin3   = tc3;
            start3 = 1'b1;
            exp_q3.push_back(4'(ta3) + 4'(tb3) + 4'(tc3));
            seen3 = 1'b0;
            for (int j = 0; j < 12 && !seen3; j++) begin
                tick();
                if (done3) seen3 = 1'b1;
            end
            check("w3_done_seen", {31'd0, seen3}, 32'd1);
            if (seen3) begin
                e3 = exp_q3.pop_front();
                check("w3_result", {28'd0, cout3, sum3}, {28'd0, e3});
                if (prev_done >= 0) check("w3_spacing", cyc - prev_done, 5);
                prev_done = cyc;
            end else begin
                exp_q3.delete();
                prev_done = -1;
            end
        end
        start3 = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
